tex_dcr_regfile: RTL

- Responder end of the texture DCR interface. Accepts host DCR writes and stores one texture-state record per sampler stage.
- Serves two registered, handshaked read paths:
  - a lookup port that returns the full per-stage record to the texture sampler pipeline;
  - a readback port that returns single DCR words to the host.
- Sits between the DCR bus and the tex unit, replacing hardwired state wiring.

---
 rtl/tex_dcr_regfile_pkg.sv | 35 +++
 rtl/tex_dcr_regfile_rsp_reg.sv | 34 +++
 rtl/tex_dcr_regfile.sv | 135 +++++++++++++
 3 files changed

// File: rtl/tex_dcr_regfile_pkg.sv
// Texture DCR types: field widths, DCR register offsets and the per-stage state record.
package tex_dcr_regfile_pkg;

   localparam int unsigned TEX_LOD_MAX      = 11;
   localparam int unsigned TEX_NUM_LODS     = TEX_LOD_MAX + 1;
   localparam int unsigned TEX_LOD_IDX_BITS = $clog2(TEX_NUM_LODS);
   localparam int unsigned TEX_DIM_BITS     = 11;
   localparam int unsigned TEX_MIPOFF_BITS  = 2 * TEX_DIM_BITS + 1;
   localparam int unsigned TEX_LOD_BITS     = 4;
   localparam int unsigned TEX_WRAP_BITS    = 2;
   localparam int unsigned TEX_FORMAT_BITS  = 3;
   localparam int unsigned TEX_FILTER_BITS  = 1;
   localparam int unsigned TEX_ADDR_BITS    = 32;

   localparam int unsigned TEX_DCR_STAGE    = 0;
   localparam int unsigned TEX_DCR_BADDR    = 1;
   localparam int unsigned TEX_DCR_FORMAT   = 2;
   localparam int unsigned TEX_DCR_FILTER   = 3;
   localparam int unsigned TEX_DCR_WRAP_U   = 4;
   localparam int unsigned TEX_DCR_WRAP_V   = 5;
   localparam int unsigned TEX_DCR_LOGDIM_U = 6;
   localparam int unsigned TEX_DCR_LOGDIM_V = 7;
   localparam int unsigned TEX_DCR_MIPOFF0  = 8;
   localparam int unsigned TEX_DCR_COUNT    = TEX_DCR_MIPOFF0 + TEX_LOD_MAX + 1;

   typedef struct packed {
      logic [TEX_NUM_LODS-1:0][TEX_MIPOFF_BITS-1:0] mipoff;
      logic [1:0][TEX_LOD_BITS-1:0]                 logdims;
      logic [1:0][TEX_WRAP_BITS-1:0]                wraps;
      logic [TEX_ADDR_BITS-1:0]                     baddr;
      logic [TEX_FORMAT_BITS-1:0]                   format;
      logic [TEX_FILTER_BITS-1:0]                   filter;
   } tex_dcrs_t;

endpackage

// File: rtl/tex_dcr_regfile_rsp_reg.sv
// Single-entry valid/ready response register; accepts a new entry whenever the slot drains this cycle.
module tex_dcr_regfile_rsp_reg #(
   parameter int unsigned W = 32
)(
   input  logic         clk,
   input  logic         reset_n,
   input  logic         i_valid,
   input  logic [W-1:0] i_data,
   output logic         o_ready_c,
   output logic         o_rsp_valid,
   output logic [W-1:0] o_rsp_data,
   input  logic         i_rsp_ready
);

   logic         r_valid;
   logic [W-1:0] r_data;

   assign o_ready_c   = !r_valid || i_rsp_ready;
   assign o_rsp_valid = r_valid;
   assign o_rsp_data  = r_data;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_valid && o_ready_c) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end else if (i_rsp_ready) begin
         r_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/tex_dcr_regfile.sv
// Texture DCR register file: host writes per-stage state; serves lookup and readback response ports.
module tex_dcr_regfile
   import tex_dcr_regfile_pkg::*;
#(
   parameter int unsigned NUM_STAGES    = 2,
   parameter int unsigned DCR_ADDR_BITS = 12,
   parameter int unsigned DCR_BASE      = 32'h040,
   localparam int unsigned SB           = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
)(
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     dcr_wr_valid,
   input  logic [DCR_ADDR_BITS-1:0] dcr_wr_addr,
   input  logic [31:0]              dcr_wr_data,
   input  logic                     lk_valid,
   input  logic [SB-1:0]            lk_stage,
   output logic                     lk_ready,
   output logic                     lk_rsp_valid,
   output tex_dcrs_t                lk_rsp_dcrs,
   input  logic                     lk_rsp_ready,
   input  logic                     rd_valid,
   input  logic [DCR_ADDR_BITS-1:0] rd_addr,
   output logic                     rd_ready,
   output logic                     rd_rsp_valid,
   output logic [31:0]              rd_rsp_data,
   input  logic                     rd_rsp_ready
);

   localparam int unsigned RW = $bits(tex_dcrs_t);

   tex_dcrs_t   r_rec [NUM_STAGES];
   logic [SB-1:0] r_cur_stage;

   tex_dcrs_t   w_cur_rec;
   tex_dcrs_t   w_wr_rec;
   logic        w_wr_field;
   logic        w_wr_stage;
   logic [31:0] w_wr_off;
   logic [31:0] w_rd_off;
   logic [TEX_LOD_IDX_BITS-1:0] w_wr_lod;
   tex_dcrs_t   w_lk_rec;
   logic [31:0] w_rd_word;
   logic [RW-1:0] w_lk_rsp_bits;

   // Offsets are 32-bit so addresses below the base wrap far outside the map.
   assign w_cur_rec = r_rec[r_cur_stage];
   assign w_wr_off  = 32'(dcr_wr_addr) - DCR_BASE;
   assign w_rd_off  = 32'(rd_addr) - DCR_BASE;
   assign w_wr_lod  = TEX_LOD_IDX_BITS'(w_wr_off - TEX_DCR_MIPOFF0);

   function automatic logic [31:0] f_read(input tex_dcrs_t rec, input logic [31:0] off,
                                          input logic [SB-1:0] stage);
      logic [TEX_LOD_IDX_BITS-1:0] lod;
      lod = TEX_LOD_IDX_BITS'(off - TEX_DCR_MIPOFF0);
      f_read = 32'h0;
      if (off < TEX_DCR_COUNT) begin
         case (off)
            TEX_DCR_STAGE:    f_read = 32'(stage);
            TEX_DCR_BADDR:    f_read = 32'(rec.baddr);
            TEX_DCR_FORMAT:   f_read = 32'(rec.format);
            TEX_DCR_FILTER:   f_read = 32'(rec.filter);
            TEX_DCR_WRAP_U:   f_read = 32'(rec.wraps[0]);
            TEX_DCR_WRAP_V:   f_read = 32'(rec.wraps[1]);
            TEX_DCR_LOGDIM_U: f_read = 32'(rec.logdims[0]);
            TEX_DCR_LOGDIM_V: f_read = 32'(rec.logdims[1]);
            default:          f_read = 32'(rec.mipoff[lod]);
         endcase
      end
   endfunction

   // Write decode: build the updated record for the current stage.
   always_comb begin
      w_wr_rec   = w_cur_rec;
      w_wr_field = 1'b0;
      w_wr_stage = 1'b0;
      if (dcr_wr_valid && (w_wr_off < TEX_DCR_COUNT)) begin
         w_wr_field = 1'b1;
         case (w_wr_off)
            TEX_DCR_STAGE: begin
               w_wr_field = 1'b0;
               w_wr_stage = (dcr_wr_data < 32'(NUM_STAGES));
            end
            TEX_DCR_BADDR:    w_wr_rec.baddr      = TEX_ADDR_BITS'(dcr_wr_data);
            TEX_DCR_FORMAT:   w_wr_rec.format     = TEX_FORMAT_BITS'(dcr_wr_data);
            TEX_DCR_FILTER:   w_wr_rec.filter     = TEX_FILTER_BITS'(dcr_wr_data);
            TEX_DCR_WRAP_U:   w_wr_rec.wraps[0]   = TEX_WRAP_BITS'(dcr_wr_data);
            TEX_DCR_WRAP_V:   w_wr_rec.wraps[1]   = TEX_WRAP_BITS'(dcr_wr_data);
            TEX_DCR_LOGDIM_U: w_wr_rec.logdims[0] = TEX_LOD_BITS'(dcr_wr_data);
            TEX_DCR_LOGDIM_V: w_wr_rec.logdims[1] = TEX_LOD_BITS'(dcr_wr_data);
            default:          w_wr_rec.mipoff[w_wr_lod] = TEX_MIPOFF_BITS'(dcr_wr_data);
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(NUM_STAGES); i++) r_rec[i] <= '0;
         r_cur_stage <= '0;
      end else begin
         if (w_wr_stage) r_cur_stage <= SB'(dcr_wr_data);
         if (w_wr_field) r_rec[r_cur_stage] <= w_wr_rec;
      end
   end

   always_comb begin
      w_lk_rec = '0;
      if (32'(lk_stage) < NUM_STAGES) w_lk_rec = r_rec[lk_stage];
   end

   assign w_rd_word   = f_read(w_cur_rec, w_rd_off, r_cur_stage);
   assign lk_rsp_dcrs = tex_dcrs_t'(w_lk_rsp_bits);

   tex_dcr_regfile_rsp_reg #(.W(RW)) u_lk_rsp (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_valid     (lk_valid),
      .i_data      (w_lk_rec),
      .o_ready_c   (lk_ready),
      .o_rsp_valid (lk_rsp_valid),
      .o_rsp_data  (w_lk_rsp_bits),
      .i_rsp_ready (lk_rsp_ready)
   );

   tex_dcr_regfile_rsp_reg #(.W(32)) u_rd_rsp (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_valid     (rd_valid),
      .i_data      (w_rd_word),
      .o_ready_c   (rd_ready),
      .o_rsp_valid (rd_rsp_valid),
      .o_rsp_data  (rd_rsp_data),
      .i_rsp_ready (rd_rsp_ready)
   );

endmodule
